adder64: RTL and testbench

//  - Registered WIDTH-bit (default 64) binary adder with carry-in and carry-out.
//  - Computes {Co,S} = A + B + Ci with a carry-lookahead tree; result registered on clk.
//  - Datapath leaf block for wide arithmetic units; one clock domain.

---
 rtl/adder_pkg.sv | 23 ++
 rtl/adder64_cla4.sv | 32 +++
 rtl/adder64.sv | 117 +++++++++++
 tb/tb_adder64.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared carry-lookahead definitions: group sizes and the generate/propagate
// combine operator used at every level of the adder tree.
package adder_pkg;

   localparam int CLA_GRP   = 4;
   localparam int SUPER_GRP = 16;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   localparam gp_t GP_IDENTITY = '{g: 1'b0, p: 1'b1};

   // hi is the more-significant span, lo the less-significant one
   function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
      gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/adder64_cla4.sv
// 4-bit carry-lookahead slice: sum bits plus group generate/propagate.
// Purely combinational; group G/P do not depend on ci.
module cla4
   import adder_pkg::*;
(
   input  logic [CLA_GRP-1:0] a,
   input  logic [CLA_GRP-1:0] b,
   input  logic               ci,
   output logic [CLA_GRP-1:0] s,
   output logic               g,
   output logic               p
);

   logic [CLA_GRP-1:0] bit_g;
   logic [CLA_GRP-1:0] bit_p;
   logic [CLA_GRP-1:0] c;

   assign bit_g = a & b;
   assign bit_p = a ^ b;

   assign c[0] = ci;
   assign c[1] = bit_g[0] | (bit_p[0] & ci);
   assign c[2] = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & ci);
   assign c[3] = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0])
               | (bit_p[2] & bit_p[1] & bit_p[0] & ci);

   assign s = bit_p ^ c;
   assign g = bit_g[3] | (bit_p[3] & bit_g[2]) | (bit_p[3] & bit_p[2] & bit_g[1])
            | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);
   assign p = &bit_p;

endmodule

// File: rtl/adder64.sv
// Registered WIDTH-bit three-level carry-lookahead adder with carry in/out.
// Define ADDER64_OVF_EN to add the registered signed-overflow output V.
module adder64
   import adder_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ci,
   output logic [WIDTH-1:0] S,
   output logic             Co
`ifdef ADDER64_OVF_EN
   ,
   output logic             V
`endif
);

   localparam int NGRP = WIDTH / CLA_GRP;
   localparam int NBLK = WIDTH / SUPER_GRP;
   localparam int GPB  = SUPER_GRP / CLA_GRP;

   logic [NGRP-1:0]  grp_g;
   logic [NGRP-1:0]  grp_p;
   logic [NGRP-1:0]  grp_c;
   gp_t              blk_gp [NBLK];
   logic [NBLK:0]    blk_c;
   logic [WIDTH-1:0] s_d, s_q;
   logic             co_d, co_q;

   generate
      for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
         cla4 u_cla4 (
            .a  (A[gi*CLA_GRP +: CLA_GRP]),
            .b  (B[gi*CLA_GRP +: CLA_GRP]),
            .ci (grp_c[gi]),
            .s  (s_d[gi*CLA_GRP +: CLA_GRP]),
            .g  (grp_g[gi]),
            .p  (grp_p[gi])
         );
      end

      // Second level: block G/P and group carries inside each 16-bit block.
      // Kept as two processes so block G/P never appears to depend on blk_c.
      for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
         logic [GPB-1:0] c_loc;

         always_comb begin
            gp_t acc;
            acc = GP_IDENTITY;
            for (int j = 0; j < GPB; j++) begin
               acc = gp_combine('{g: grp_g[gi*GPB+j], p: grp_p[gi*GPB+j]}, acc);
            end
            blk_gp[gi] = acc;
         end

         always_comb begin
            gp_t acc;
            c_loc = '0;
            acc   = GP_IDENTITY;
            for (int j = 0; j < GPB; j++) begin
               c_loc[j] = acc.g | (acc.p & blk_c[gi]);
               acc = gp_combine('{g: grp_g[gi*GPB+j], p: grp_p[gi*GPB+j]}, acc);
            end
         end

         assign grp_c[gi*GPB +: GPB] = c_loc;
      end
   endgenerate

   // Third level: each block carry is a prefix of block G/P applied to Ci
   always_comb begin
      gp_t acc;
      blk_c = '0;
      acc   = GP_IDENTITY;
      for (int k = 0; k <= NBLK; k++) begin
         blk_c[k] = acc.g | (acc.p & Ci);
         if (k < NBLK) begin
            acc = gp_combine(blk_gp[k], acc);
         end
      end
   end

   assign co_d = blk_c[NBLK];

`ifdef ADDER64_OVF_EN
   logic v_d, v_q;
   // carry into the MSB is recovered as a ^ b ^ s at that bit
   assign v_d = (A[WIDTH-1] ^ B[WIDTH-1] ^ s_d[WIDTH-1]) ^ co_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= 1'b0;
      end else begin
         v_q <= v_d;
      end
   end

   assign V = v_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q  <= '0;
         co_q <= 1'b0;
      end else begin
         s_q  <= s_d;
         co_q <= co_d;
      end
   end

   assign S  = s_q;
   assign Co = co_q;

endmodule

// File: tb/tb_adder64.sv
// Directed and random checks of the registered adder64; V checked when
// ADDER64_OVF_EN is defined.
`timescale 1ns/1ps
module tb_adder64;

   logic        clk;
   logic        rst_n;
   logic [63:0] a_i;
   logic [63:0] b_i;
   logic        ci_i;
   logic [63:0] s_o;
   logic        co_o;
`ifdef ADDER64_OVF_EN
   logic        v_o;
`endif

   int n_checks;
   int n_fail;

   adder64 #(.WIDTH(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (a_i),
      .B     (b_i),
      .Ci    (ci_i),
      .S     (s_o),
      .Co    (co_o)
`ifdef ADDER64_OVF_EN
      ,
      .V     (v_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed={Co,S}=%h expected=%h", tag, obs, exp);
      end
      $display("check %-12s {Co,S}=%h", tag, obs);
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
      $display("check %-12s bit=%b", tag, obs);
   endtask

   task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic ci);
      a_i  = a;
      b_i  = b;
      ci_i = ci;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic        rc;
      logic [64:0] model;
      n_checks = 0;
      n_fail   = 0;

      // reset held with maximal inputs and clocks running
      rst_n = 1'b0;
      drive('1, '1, 1'b1);
      #1;
      check("rst_t0", {co_o, s_o}, 65'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_hold", {co_o, s_o}, 65'd0);
      end
`ifdef ADDER64_OVF_EN
      check_bit("rst_v", v_o, 1'b0);
`endif

      rst_n = 1'b1;
      drive(64'd0, 64'd0, 1'b0);
      tick();
      check("zero", {co_o, s_o}, 65'd0);

      drive(64'hFFC00FFCD4DCA95C, 64'hFFFFF003D759B69B, 1'b0);
      tick();
      check("mixed", {co_o, s_o}, {1'b1, 64'hFFC00000AC365FF7});

      drive(64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
      tick();
      check("ripple", {co_o, s_o}, {1'b1, 64'd0});

      drive(64'd1, 64'd1, 1'b0);
      tick();
      check("b2b_1", {co_o, s_o}, 65'd2);
      drive(64'd2, 64'd3, 1'b1);
      tick();
      check("b2b_2", {co_o, s_o}, 65'd6);

      // input changes between edges must not reach the outputs
      drive(64'd5, 64'd5, 1'b0);
      #3;
      check("mid_hold", {co_o, s_o}, 65'd6);
      tick();
      check("mid_next", {co_o, s_o}, 65'd10);

      drive(64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0);
      tick();
      check("ovf", {co_o, s_o}, {1'b0, 64'h8000000000000000});
`ifdef ADDER64_OVF_EN
      check_bit("ovf_v", v_o, 1'b1);
`endif

      drive(64'h8000000000000000, 64'h8000000000000000, 1'b0);
      tick();
      check("neg_ovf", {co_o, s_o}, {1'b1, 64'd0});
`ifdef ADDER64_OVF_EN
      check_bit("neg_ovf_v", v_o, 1'b1);
`endif

      drive(64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0);
      tick();
      check("m1_plus1", {co_o, s_o}, {1'b1, 64'd0});
`ifdef ADDER64_OVF_EN
      check_bit("m1_plus1_v", v_o, 1'b0);
`endif

      // asynchronous reset mid-cycle, then recovery
      drive(64'd100, 64'd23, 1'b1);
      tick();
      check("pre_arst", {co_o, s_o}, 65'd124);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_now", {co_o, s_o}, 65'd0);
      tick();
      check("arst_hold", {co_o, s_o}, 65'd0);
      rst_n = 1'b1;
      drive(64'd3, 64'd4, 1'b0);
      tick();
      check("arst_rel", {co_o, s_o}, 65'd7);

      for (int i = 0; i < 10000; i++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         rc = 1'($urandom_range(0, 1));
         if (i % 16 == 0) ra = '1;
         if (i % 16 == 1) rb = ~ra;
         drive(ra, rb, rc);
         model = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
         @(posedge clk);
         #1;
         n_checks++;
         assert ({co_o, s_o} === model) else begin
            n_fail++;
            $error("FAIL rand[%0d] a=%h b=%h ci=%b observed=%h expected=%h",
                   i, ra, rb, rc, {co_o, s_o}, model);
         end
`ifdef ADDER64_OVF_EN
         n_checks++;
         assert (v_o === ((ra[63] == rb[63]) && (model[63] != ra[63]))) else begin
            n_fail++;
            $error("FAIL rand_v[%0d] observed=%b", i, v_o);
         end
`endif
      end
      $display("random: 10000 vectors applied");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
